// File: rtl/multiphase_clk_gen.sv
// -----------------------------------------------------------------------------
// multiphase_clk_gen
//
// Derives NUM_PHASES evenly spaced, overlapping 50%-duty phase clocks from a
// single master clock, together with a stretched, software-retriggerable
// active-low system reset for downstream blocks.
//
// A slot counter s walks 0..2N-1; each slot lasts `step` master cycles
// (counted by c). Phase i is high while s sits in the N slots starting at i.
// Stopping is graceful: each phase is masked off only at its natural falling
// edge, so no output ever produces a shortened pulse.
//
// Ports:
//   CLOCK       master clock, all logic on the rising edge
//   RESET       asynchronous active-low reset
//   RUN         level: 1 = generate phases, 0 = stop cleanly
//   STEP_LOAD   one-cycle request to load STEP_VAL
//   STEP_VAL    new slot length in master cycles (0 behaves as 1)
//   STEP_ACK    one-cycle pulse when a new step takes effect
//   SW_RESET    synchronous pulse retriggering the reset sequence
//   PHASE_CLK   registered phase clocks
//   PHASE_RISE  strobe in the cycle PHASE_CLK[i] goes 0->1
//   SYS_RESET   registered active-low system reset
//   ACTIVE      1 whenever the generator is not idle
// -----------------------------------------------------------------------------
module multiphase_clk_gen #(
    parameter int NUM_PHASES = 4,
    parameter int STEP_W     = 8,
    parameter int DEF_STEP   = 2,
    parameter int RST_HOLD   = 16,
    parameter int RST_W      = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  RUN,
    input  logic                  STEP_LOAD,
    input  logic [STEP_W-1:0]     STEP_VAL,
    output logic                  STEP_ACK,
    input  logic                  SW_RESET,
    output logic [NUM_PHASES-1:0] PHASE_CLK,
    output logic [NUM_PHASES-1:0] PHASE_RISE,
    output logic                  SYS_RESET,
    output logic                  ACTIVE
);

    localparam int TWO_N = 2 * NUM_PHASES;
    localparam int S_W   = $clog2(TWO_N);

    localparam logic [S_W-1:0]    LAST_SLOT  = S_W'(TWO_N - 1);
    localparam logic [STEP_W-1:0] DEF_STEP_V = STEP_W'(DEF_STEP);
    localparam logic [RST_W-1:0]  HOLD_LAST  = RST_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [STEP_W-1:0]     c;
    logic [STEP_W-1:0]     next_c;
    logic [S_W-1:0]        s;
    logic [S_W-1:0]        next_s;
    logic [NUM_PHASES-1:0] mask;
    logic [NUM_PHASES-1:0] next_mask;
    logic [NUM_PHASES-1:0] next_phase;

    logic [STEP_W-1:0]     step;
    logic                  pend_flag;
    logic [STEP_W-1:0]     pend_val;
    logic [STEP_W-1:0]     load_val;

    logic [RST_W-1:0]      hold_cnt;

    logic                  running;
    logic                  adv;
    logic                  wrap;

    // Phase i is high while (slot - i) mod 2N lies in the first half.
    function automatic logic slot_high(input logic [S_W-1:0] slot, input int idx);
        int rel;
        rel = int'(slot) - idx;
        if (rel < 0) begin
            rel = rel + TWO_N;
        end
        return (rel < NUM_PHASES);
    endfunction

    // Slot in which phase idx drops low.
    function automatic logic [S_W-1:0] fall_slot(input int idx);
        return S_W'((idx + NUM_PHASES) % TWO_N);
    endfunction

    // A zero step would never advance the slot counter, so it is clamped to 1.
    assign load_val = (STEP_VAL == '0) ? STEP_W'(1) : STEP_VAL;

    // adv marks the last cycle of a slot; wrap marks the last cycle of a period.
    assign running = (state != ST_IDLE);
    assign adv     = running && (c == step - STEP_W'(1));
    assign wrap    = adv && (s == LAST_SLOT);

    // Next-state logic: counters advance whenever the generator is active;
    // while stopping, each phase is masked as its slot reaches its falling edge.
    always_comb begin
        next_state = state;
        next_c     = c;
        next_s     = s;
        next_mask  = mask;

        if (running) begin
            if (adv) begin
                next_c = '0;
                next_s = wrap ? '0 : s + S_W'(1);
            end else begin
                next_c = c + STEP_W'(1);
            end
        end

        case (state)
            ST_IDLE: begin
                if (RUN) begin
                    next_state = ST_RUN;
                    next_c     = '0;
                    next_s     = '0;
                    next_mask  = '0;
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    next_mask = '0;
                end
                if (!RUN) begin
                    next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                for (int i = 0; i < NUM_PHASES; i++) begin
                    if (adv && (next_s == fall_slot(i))) begin
                        next_mask[i] = 1'b1;
                    end
                end
                if (RUN) begin
                    // Resuming: masked phases stay quiet until the period restarts.
                    next_state = ST_RUN;
                    if (wrap) begin
                        next_mask = '0;
                    end
                end else if (&mask) begin
                    next_state = ST_IDLE;
                    next_c     = '0;
                    next_s     = '0;
                    next_mask  = '0;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Phase outputs are decoded from the next slot so the registered clocks
    // change in the same cycle the slot counter does.
    always_comb begin
        next_phase = '0;
        if (next_state != ST_IDLE) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                next_phase[i] = !next_mask[i] && slot_high(next_s, i);
            end
        end
    end

    // State, counters and registered phase outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            c          <= '0;
            s          <= '0;
            mask       <= '0;
            PHASE_CLK  <= '0;
            PHASE_RISE <= '0;
            ACTIVE     <= 1'b0;
        end else begin
            state      <= next_state;
            c          <= next_c;
            s          <= next_s;
            mask       <= next_mask;
            PHASE_CLK  <= next_phase;
            PHASE_RISE <= next_phase & ~PHASE_CLK;
            ACTIVE     <= (next_state != ST_IDLE);
        end
    end

    // Step register: loads apply immediately while idle, otherwise they wait
    // for the period boundary so a period is never built from two step values.
    // A load sampled on the wrap cycle itself waits for the following wrap.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            step      <= DEF_STEP_V;
            pend_flag <= 1'b0;
            pend_val  <= DEF_STEP_V;
            STEP_ACK  <= 1'b0;
        end else begin
            STEP_ACK <= 1'b0;
            if (state == ST_IDLE) begin
                if (STEP_LOAD) begin
                    step      <= load_val;
                    STEP_ACK  <= 1'b1;
                    pend_flag <= 1'b0;
                end
            end else begin
                if (wrap && pend_flag) begin
                    step      <= pend_val;
                    STEP_ACK  <= 1'b1;
                    pend_flag <= 1'b0;
                end
                if (STEP_LOAD) begin
                    pend_flag <= 1'b1;
                    pend_val  <= load_val;
                end
            end
        end
    end

    // Reset sequencer: SYS_RESET is held low for RST_HOLD cycles after either
    // the hard reset or a software pulse; a new pulse restarts the count.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            hold_cnt  <= '0;
            SYS_RESET <= 1'b0;
        end else if (SW_RESET) begin
            hold_cnt  <= '0;
            SYS_RESET <= 1'b0;
        end else if (!SYS_RESET) begin
            if (hold_cnt == HOLD_LAST) begin
                SYS_RESET <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + RST_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multiphase_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_multiphase_clk_gen
//
// Scoreboarded bench for multiphase_clk_gen. Every clock edge the stimulus
// side advances a time-based reference model (position within the period,
// divided by the step, gives the slot) and queues the expected outputs; an
// independent monitor pops one entry per cycle and compares it.
// -----------------------------------------------------------------------------
module tb_multiphase_clk_gen;

    localparam int N        = 4;
    localparam int STEP_W   = 8;
    localparam int DEF_STEP = 2;
    localparam int RST_HOLD = 16;

    logic              CLOCK;
    logic              RESET;
    logic              RUN;
    logic              STEP_LOAD;
    logic [STEP_W-1:0] STEP_VAL;
    logic              STEP_ACK;
    logic              SW_RESET;
    logic [N-1:0]      PHASE_CLK;
    logic [N-1:0]      PHASE_RISE;
    logic              SYS_RESET;
    logic              ACTIVE;

    multiphase_clk_gen #(
        .NUM_PHASES (N),
        .STEP_W     (STEP_W),
        .DEF_STEP   (DEF_STEP),
        .RST_HOLD   (RST_HOLD),
        .RST_W      (8)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .RUN        (RUN),
        .STEP_LOAD  (STEP_LOAD),
        .STEP_VAL   (STEP_VAL),
        .STEP_ACK   (STEP_ACK),
        .SW_RESET   (SW_RESET),
        .PHASE_CLK  (PHASE_CLK),
        .PHASE_RISE (PHASE_RISE),
        .SYS_RESET  (SYS_RESET),
        .ACTIVE     (ACTIVE)
    );

    typedef struct {
        logic [N-1:0] phase;
        logic [N-1:0] rise;
        logic         ack;
        logic         sys;
        logic         active;
    } exp_t;

    exp_t expQ[$];

    int errCount   = 0;
    int checkCount = 0;

    // Reference model state: 0 idle, 1 running, 2 stopping.
    int       mState;
    int       mT;
    int       mStep;
    bit       mPend;
    int       mPendVal;
    bit [N-1:0] mDone;
    bit [N-1:0] mPrevPhase;
    int       edgeCnt   = 0;
    int       holdStart = 0;
    bit       inReset   = 1'b1;

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    function automatic int normStep(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    // Natural (unmasked) level of phase i at position t of a period.
    function automatic bit natHigh(input int t, input int stp, input int i);
        int slot;
        slot = t / stp;
        return (((slot - i + 2 * N) % (2 * N)) < N);
    endfunction

    task automatic modelReset();
        inReset    = 1'b1;
        mState     = 0;
        mT         = 0;
        mStep      = DEF_STEP;
        mPend      = 1'b0;
        mPendVal   = DEF_STEP;
        mDone      = '0;
        mPrevPhase = '0;
    endtask

    task automatic modelRelease();
        inReset   = 1'b0;
        holdStart = edgeCnt;
    endtask

    // Advance the reference by one clock edge and queue the expected outputs.
    task automatic modelEdge(input bit run, input bit load, input int val, input bit sw);
        exp_t       e;
        bit         wrapping;
        bit         ack;
        int         newStep;
        int         tNext;
        bit [N-1:0] doneBefore;
        bit [N-1:0] ph;

        edgeCnt++;
        if (inReset) begin
            e.phase  = '0;
            e.rise   = '0;
            e.ack    = 1'b0;
            e.sys    = 1'b0;
            e.active = 1'b0;
            expQ.push_back(e);
            return;
        end

        wrapping = (mState != 0) && (mT == 2 * N * mStep - 1);
        newStep  = mStep;
        ack      = 1'b0;
        if (mState == 0) begin
            if (load) begin
                newStep = normStep(val);
                ack     = 1'b1;
                mPend   = 1'b0;
            end
        end else begin
            if (wrapping && mPend) begin
                newStep = mPendVal;
                ack     = 1'b1;
                mPend   = 1'b0;
            end
            if (load) begin
                mPend    = 1'b1;
                mPendVal = normStep(val);
            end
        end

        doneBefore = mDone;
        if (mState == 0) begin
            if (run) begin
                mState = 1;
                mT     = 0;
                mDone  = '0;
            end
        end else begin
            tNext = wrapping ? 0 : mT + 1;
            if (mState == 2) begin
                for (int i = 0; i < N; i++) begin
                    if (natHigh(mT, mStep, i) && !natHigh(tNext, newStep, i)) begin
                        mDone[i] = 1'b1;
                    end
                end
            end
            mT = tNext;
            if (mState == 1) begin
                if (wrapping) mDone = '0;
                if (!run) mState = 2;
            end else if (run) begin
                mState = 1;
                if (wrapping) mDone = '0;
            end else if (&doneBefore) begin
                mState = 0;
                mT     = 0;
                mDone  = '0;
            end
        end
        mStep = newStep;

        if (sw) holdStart = edgeCnt;

        for (int i = 0; i < N; i++) begin
            ph[i] = (mState != 0) && !mDone[i] && natHigh(mT, mStep, i);
        end
        e.phase    = ph;
        e.rise     = ph & ~mPrevPhase;
        mPrevPhase = ph;
        e.ack      = ack;
        e.sys      = ((edgeCnt - holdStart) >= RST_HOLD);
        e.active   = (mState != 0);
        expQ.push_back(e);
    endtask

    task automatic checkBits(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s at edge %0d: got %0h expected %0h", name, edgeCnt, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkBits("phaseClk",  32'(PHASE_CLK),  32'(e.phase));
        checkBits("phaseRise", 32'(PHASE_RISE), 32'(e.rise));
        checkBits("stepAck",   32'(STEP_ACK),   32'(e.ack));
        checkBits("sysReset",  32'(SYS_RESET),  32'(e.sys));
        checkBits("active",    32'(ACTIVE),     32'(e.active));
    endtask

    // Drive one cycle of inputs, then let the model consume the same edge.
    task automatic applyStimulus(input bit run, input bit load, input int val, input bit sw);
        RUN       = run;
        STEP_LOAD = load;
        STEP_VAL  = STEP_W'(val);
        SW_RESET  = sw;
        @(posedge CLOCK);
        modelEdge(run, load, val, sw);
        #1;
    endtask

    // Monitor: one expected entry per cycle, compared away from the active edge.
    initial begin
        exp_t cur;
        forever begin
            @(negedge CLOCK);
            if (expQ.size() > 0) begin
                cur = expQ.pop_front();
                checkOutput(cur);
            end
        end
    end

    initial begin
        int runHold;
        bit runLvl;

        RESET     = 1'b1;
        RUN       = 1'b0;
        STEP_LOAD = 1'b0;
        STEP_VAL  = '0;
        SW_RESET  = 1'b0;
        runHold   = 0;
        runLvl    = 1'b0;
        #2;
        RESET = 1'b0;
        modelReset();
        $display("[TB] power-on reset");
        repeat (3) applyStimulus(0, 0, 0, 0);
        #2;
        RESET = 1'b1;
        modelRelease();

        // Idle after release: reset stretch only.
        repeat (20) applyStimulus(0, 0, 0, 0);

        // Start with the default step and let a few periods run.
        repeat (40) applyStimulus(1, 0, 0, 0);

        // Drop RUN mid-period, reassert while stopping, then stop fully.
        repeat (3)  applyStimulus(1, 0, 0, 0);
        repeat (6)  applyStimulus(0, 0, 0, 0);
        repeat (30) applyStimulus(1, 0, 0, 0);
        repeat (30) applyStimulus(0, 0, 0, 0);

        // Step loads while running: 3 then 4 before the wrap, later 0.
        repeat (10) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 3, 0);
        repeat (3)  applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 4, 0);
        repeat (80) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        repeat (50) applyStimulus(1, 0, 0, 0);

        // Software reset retriggered during its own hold.
        applyStimulus(1, 0, 0, 1);
        repeat (4)  applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1);
        repeat (30) applyStimulus(1, 0, 0, 0);

        // Stop, then load a step while idle.
        repeat (40) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 5, 0);
        repeat (5)  applyStimulus(0, 0, 0, 0);

        // Randomized traffic.
        for (int k = 0; k < 2500; k++) begin
            if (runHold == 0) begin
                runLvl  = ($urandom_range(0, 2) != 0);
                runHold = $urandom_range(3, 70);
            end
            runHold--;
            applyStimulus(runLvl, ($urandom_range(0, 15) == 0),
                          $urandom_range(0, 5), ($urandom_range(0, 59) == 0));
        end

        // Asynchronous reset in the middle of a run.
        repeat (25) applyStimulus(1, 0, 0, 0);
        @(negedge CLOCK);
        #1;
        RESET = 1'b0;
        #1;
        checkBits("asyncPhaseClk",  32'(PHASE_CLK),  32'd0);
        checkBits("asyncPhaseRise", 32'(PHASE_RISE), 32'd0);
        checkBits("asyncStepAck",   32'(STEP_ACK),   32'd0);
        checkBits("asyncSysReset",  32'(SYS_RESET),  32'd0);
        checkBits("asyncActive",    32'(ACTIVE),     32'd0);
        modelReset();
        repeat (3) applyStimulus(1, 0, 0, 0);
        #2;
        RESET = 1'b1;
        modelRelease();
        repeat (40) applyStimulus(1, 0, 0, 0);
        repeat (40) applyStimulus(0, 0, 0, 0);

        @(negedge CLOCK);
        #1;
        checkBits("queueDrained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/multiphase_clk_gen.md
Name: multiphase_clk_gen

Overview:
Synthesizable multi-phase clock and reset generator, the parametrised successor to the fixed four-clock stimulus used around CPUsystem. It derives NUM_PHASES evenly spaced, overlapping 50%-duty phase clocks from one master clock. Spacing is run-time programmable, and the generator starts and stops without runt pulses. A reset sequencer provides a stretched, software-retriggerable system reset to the CPU and BJ blocks.

Parameters:
NUM_PHASES, 4, number of phase outputs (≥2)
STEP_W, 8, width of the run-time step register
DEF_STEP, 2, step value after reset (master cycles per slot)
RST_HOLD, 16, master cycles SYS_RESET stays low after the reset source releases (≥1)
RST_W, 8, width of the hold counter (2^RST_W > RST_HOLD)

Ports:
CLOCK  in  1  master clock; all logic on the rising edge
RESET  in  1  asynchronous, active-low reset
RUN  in  1  level; 1 = generate phases, 0 = stop cleanly
STEP_LOAD  in  1  one-cycle request to load STEP_VAL
STEP_VAL  in  STEP_W  new slot length in master cycles; 0 is treated as 1
STEP_ACK  out  1  one-cycle pulse when the new step takes effect
SW_RESET  in  1  synchronous pulse; retriggers the reset sequence
PHASE_CLK  out  NUM_PHASES  registered phase clocks
PHASE_RISE  out  NUM_PHASES  one-cycle strobe in the cycle PHASE_CLK[i] goes 0→1
SYS_RESET  out  1  active-low, registered system reset to downstream blocks
ACTIVE  out  1  1 whenever the generator is not IDLE

Behaviour:
- Reset (RESET=0, asynchronous) sets PHASE_CLK=0, PHASE_RISE=0, STEP_ACK=0, ACTIVE=0, SYS_RESET=0, step=DEF_STEP, pending-load flag clear, state IDLE, all counters 0.
- Counters:
  - c counts 0..step-1.
  - Slot s counts 0..2*NUM_PHASES-1 and advances (wrapping) when c==step-1.
  - Period = 2*NUM_PHASES*step cycles; phase spacing = step cycles.
- Phase function: PHASE_CLK[i] = 1 iff ((s - i) mod 2N) < N and mask[i]==0. The output is registered, so it changes in the same cycle s changes.
- FSM IDLE:
  - Outputs 0, ACTIVE=0.
  - RUN=1 in cycle t → RUN state at t+1 with s=0, c=0, mask=0, PHASE_CLK[0]=1, ACTIVE=1.
  - Phase i rises at t+1+i*step.
- FSM RUN:
  - RUN=0 → STOPPING.
  - Counters keep running; no output changes on this transition.
- FSM STOPPING:
  - Counters keep running.
  - mask[i] is set in the cycle PHASE_CLK[i] would fall (s becomes (i+N) mod 2N), so each phase ends on its natural falling edge and never produces a runt.
  - Phases not yet risen complete a full pulse.
  - All masks set → IDLE next cycle; ACTIVE falls with the transition.
  - RUN=1 during STOPPING → back to RUN; masks clear only at the next wrap to s=0.
- Step load:
  - STEP_LOAD in IDLE: applies next cycle and STEP_ACK pulses.
  - Otherwise the value is held pending and applied in the cycle s wraps 2N-1→0; STEP_ACK pulses that cycle.
  - A new STEP_LOAD while pending overwrites the pending value; only one ACK is issued.
  - A load coincident with the wrap cycle is deferred to the next wrap.
- Reset sequencer:
  - After RESET releases, SYS_RESET stays 0 for exactly RST_HOLD cycles, then goes 1.
  - SW_RESET=1 in cycle t → SYS_RESET=0 from t+1 for RST_HOLD cycles.
  - SW_RESET during an active hold restarts the count.
  - Phase generation is independent of SYS_RESET: clocks keep running through a software reset.
- Width rules: s uses clog2(2N) bits; wrap uses explicit compare, not natural overflow.

Test Plan:
1. RESET low→high, RUN=0 → all outputs 0 through reset; SYS_RESET rises exactly 16 cycles after release; PHASE_CLK stays 0.
2. N=4, step=2, RUN high at t → PHASE_CLK[0..3] rise at t+1, t+3, t+5, t+7; each is high 8 and low 8 cycles (period 16); PHASE_RISE pulses once per rise.
3. RUN dropped mid-period → each phase finishes its high time, no pulse shorter than 8 cycles, ACTIVE→0 within 16 cycles; RUN reasserted in STOPPING → masks clear at the next s=0 and normal pattern resumes.
4. STEP_LOAD=3 mid-period, then STEP_LOAD=4 before wrap → one STEP_ACK at the wrap; following period is 32 cycles with 4-cycle spacing; STEP_VAL=0 gives period 8.
5. SW_RESET at cycle t while running, repeated at t+5 → SYS_RESET low from t+1 to t+21 inclusive, high at t+22; PHASE_CLK is uninterrupted throughout.
6. RESET asserted mid-run → all outputs 0 immediately (asynchronously), step returns to DEF_STEP, state IDLE after release.
